// File: rtl/sort_seq_ctrl.sv
// rtl/sort_seq_ctrl.sv - block bubble sorter sharing one comparator; SORT_DESCEND_EN selects descending order

// Single shared unsigned magnitude comparator.
module sort_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             is_equal,
  output logic             is_great,
  output logic             is_less
);
  assign is_equal = (a == b);
  assign is_great = (a > b);
  assign is_less  = (a < b);
endmodule

module sort_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             sort_done,
  output logic [15:0]      cmp_count
);

  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_J0  = IDX_W'(DEPTH - 2);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] load_idx, out_idx, j, pass;
  logic [IDX_W-1:0] j_nx;
  logic             swap_flag;
  logic [15:0]      cmp_cnt;
  logic             sort_done_q;

  logic             is_equal, is_great, is_less;
  logic             swap_cond, last_j;
  logic             load_fire, out_fire, do_swap, pass_end, sort_exit;

  assign j_nx      = j + IDX_ONE;
  assign last_j    = (j == (LAST_J0 - pass));
  assign sort_done = sort_done_q;
  assign cmp_count = cmp_cnt;

  sort_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a        (mem[j]),
    .b        (mem[j_nx]),
    .is_equal (is_equal),
    .is_great (is_great),
    .is_less  (is_less)
  );

  // Equal words never swap, which keeps the sort stable in either order.
`ifdef SORT_DESCEND_EN
  assign swap_cond = !is_equal && is_less;
`else
  assign swap_cond = !is_equal && is_great;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  // Next-state decode, handshake outputs and per-cycle datapath strobes.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    load_fire = 1'b0;
    out_fire  = 1'b0;
    do_swap   = 1'b0;
    pass_end  = 1'b0;
    sort_exit = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready  = 1'b1;
        load_fire = in_valid;
        if (in_valid && load_idx == LAST_IDX) state_nxt = S_SORT;
      end
      S_SORT: begin
        busy    = 1'b1;
        do_swap = swap_cond;
        if (last_j) begin
          pass_end = 1'b1;
          // A pass with no swap (this cycle included) proves the block is ordered.
          if (!(swap_flag || swap_cond) || pass == LAST_J0) begin
            sort_exit = 1'b1;
            state_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_data  = mem[out_idx];
        out_fire  = out_ready;
        if (out_ready && out_idx == LAST_IDX) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Word array: written while loading, pairwise exchanged while sorting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_fire) begin
      mem[load_idx] <= in_data;
    end else if (do_swap) begin
      mem[j]    <= mem[j_nx];
      mem[j_nx] <= mem[j];
    end
  end

  // Index counters, pass tracking, compare counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_idx    <= '0;
      out_idx     <= '0;
      j           <= '0;
      pass        <= '0;
      swap_flag   <= 1'b0;
      cmp_cnt     <= '0;
      sort_done_q <= 1'b0;
    end else begin
      sort_done_q <= sort_exit;
      case (state)
        S_LOAD: begin
          if (load_fire) begin
            if (load_idx == LAST_IDX) begin
              load_idx  <= '0;
              pass      <= '0;
              j         <= '0;
              swap_flag <= 1'b0;
              cmp_cnt   <= '0;
            end else begin
              load_idx <= load_idx + IDX_ONE;
            end
          end
        end
        S_SORT: begin
          cmp_cnt <= cmp_cnt + 16'd1;
          if (pass_end) begin
            if (!sort_exit) begin
              pass      <= pass + IDX_ONE;
              j         <= '0;
              swap_flag <= 1'b0;
            end
          end else begin
            j         <= j_nx;
            swap_flag <= swap_flag | do_swap;
          end
        end
        S_OUT: begin
          if (out_fire) out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// tb/tb_sort_seq_ctrl.sv - scoreboard bench for sort_seq_ctrl
module tb_sort_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             sort_done;
  logic [15:0]      cmp_count;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [31:0] data;
    int          tag;
  } sb_t;
  sb_t sb_q[$];

  typedef logic [31:0] blk_t [DEPTH];
  blk_t vals;

  sort_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .sort_done (sort_done),
    .cmp_count (cmp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit goes_before(input logic [31:0] a, input logic [31:0] b);
`ifdef SORT_DESCEND_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

  // Stable insertion sort of tagged words; equal words keep load order.
  task automatic push_expected(input blk_t v);
    sb_t e[$];
    sb_t item;
    for (int i = 0; i < DEPTH; i++) begin
      int pos;
      pos = e.size();
      for (int k = 0; k < e.size(); k++) begin
        if (goes_before(v[i], e[k].data)) begin
          pos = k;
          break;
        end
      end
      item.data = v[i];
      item.tag  = i;
      e.insert(pos, item);
    end
    foreach (e[k]) sb_q.push_back(e[k]);
  endtask

  task automatic load_words(input blk_t v);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check($sformatf("in_ready_load%0d", i), in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = v[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_block(input blk_t v, input int stall, input bit toggle,
                           input int exp_cmp, input bit junk_in);
    int cyc;
    int got;
    bit was_stall;
    logic [31:0] held;
    sb_t e;
    push_expected(v);
    load_words(v);
    cyc = 0;
    if (junk_in) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
    end
    while (busy && cyc < 64) begin
      if (sort_done !== 1'b0 || out_valid !== 1'b0) check("sort_phase_outputs", {sort_done, out_valid}, 0);
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("sort_cycles", cyc, exp_cmp);
    check("sort_done_first", sort_done, 1'b1);
    check("out_valid_first", out_valid, 1'b1);
    check("cmp_count_out", cmp_count, exp_cmp);
    cyc = 0;
    got = 0;
    was_stall = 1'b0;
    held = '0;
    while (got < DEPTH && cyc < 200) begin
      if (cyc < stall) out_ready = 1'b0;
      else if (toggle) out_ready = ((cyc - stall) % 2 == 0);
      else out_ready = 1'b1;
      if (was_stall) check("stall_hold", out_data, held);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("out%0d_tag%0d", got, e.tag), out_data, e.data);
        end
        got++;
        was_stall = 1'b0;
      end else if (out_valid) begin
        held = out_data;
        was_stall = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("sort_done_pulse", sort_done, 1'b0);
    end
    out_ready = 1'b0;
    check("words_drained", got, DEPTH);
    check("sb_left", sb_q.size(), 0);
    check("in_ready_after", in_ready, 1'b1);
    check("out_valid_after", out_valid, 1'b0);
    check("out_data_after", out_data, 0);
    check("cmp_count_kept", cmp_count, exp_cmp);
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_sort_done", sort_done, 1'b0);
    check("rst_cmp_count", cmp_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SORT_DESCEND_EN
    vals = '{32'd1, 32'd3, 32'd2, 32'd4};
    run_block(vals, 0, 1'b0, 6, 1'b0);
    vals = '{32'd4, 32'd3, 32'd2, 32'd1};
    run_block(vals, 0, 1'b0, 3, 1'b0);
`else
    vals = '{32'd4, 32'd3, 32'd2, 32'd1};
    run_block(vals, 0, 1'b0, 6, 1'b1);
    vals = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_block(vals, 0, 1'b0, 3, 1'b0);
    vals = '{32'd5, 32'd5, 32'd2, 32'd5};
    run_block(vals, 0, 1'b0, 6, 1'b0);
    vals = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1};
    run_block(vals, 5, 1'b1, 6, 1'b0);
    vals = '{32'd1, 32'd3, 32'd2, 32'd4};
    run_block(vals, 0, 1'b0, 5, 1'b0);

    // Abort a block mid-sort, then confirm a fresh block is clean.
    vals = '{32'd4, 32'd3, 32'd2, 32'd1};
    load_words(vals);
    check("abort_in_sort", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_cmp_count", cmp_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    check("release_out_valid", out_valid, 1'b0);
    sb_q.delete();
    vals = '{32'd9, 32'd8, 32'd7, 32'd6};
    run_block(vals, 0, 1'b0, 6, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
